// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared AES-128 constants: round count, key width, RCON table,
//          key-schedule state encoding and the forward S-box.
// Rev    : 1.0  initial release
// ============================================================================
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  // Key-schedule FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Round constant for expansion round r (1..10); index 0 is never used
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Forward S-box, entry 0 first
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_step.sv
`default_nettype none
// ============================================================================
// Module : aes_key_expand_step
// Brief  : One AES-128 key-expansion round, purely combinational.
//          next = step(prev, rcon) using RotWord/SubWord on the last word.
// Rev    : 1.0  initial release
// ============================================================================
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [127:0] prev_key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0  = prev_key[127:96];
  assign w1  = prev_key[95:64];
  assign w2  = prev_key[63:32];
  assign w3  = prev_key[31:0];

  // RotWord: cyclic left byte rotation
  assign rot = {w3[23:0], w3[31:24]};

  // SubWord: four S-box lookups, one per byte
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule
`default_nettype wire

// File: rtl/aes_decr_key_sched.sv
`default_nettype none
// ============================================================================
// Module : aes_decr_key_sched
// Brief  : AES-128 key schedule for the decrypt path. Expands the cipher key
//          one round per cycle into an 11-entry store, then serves round keys
//          rk10..rk0 over a valid/req handshake, wrapping back to rk10.
//          Optional macro AES_KS_ZEROIZE_EN adds a key_clear input that wipes
//          the store and returns to IDLE.
// Rev    : 1.0  initial release
// ============================================================================
module aes_decr_key_sched
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             key_ready,
  output logic             rk_valid,
  input  logic             rk_req,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_idx,
  output logic             rk_last
`ifdef AES_KS_ZEROIZE_EN
  ,
  input  logic             key_clear
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [3:0]       ptr;
  logic [KEY_W-1:0] prev_key;
  logic [KEY_W-1:0] next_key;
  logic [KEY_W-1:0] store [0:NR];
  logic             clear;

`ifdef AES_KS_ZEROIZE_EN
  assign clear = key_clear;
`else
  assign clear = 1'b0;
`endif

  // Single shared expansion round; prev_key chains the most recent round key
  aes_key_expand_step u_step (
    .prev_key (prev_key),
    .rcon     (rcon(cnt)),
    .next_key (next_key)
  );

  // Status outputs decode directly from the state register
  assign busy      = (state == ST_EXPAND);
  assign key_ready = (state == ST_READY);
  assign rk_valid  = (state == ST_READY);
  assign rk_idx    = (state == ST_READY) ? ptr : 4'd0;
  assign rk_last   = (state == ST_READY) && (ptr == 4'd0);

  // FSM, key store and registered round-key output
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      ptr      <= 4'd0;
      prev_key <= '0;
      rk_out   <= '0;
      for (int i = 0; i <= NR; i++) store[i] <= '0;
    end else if (key_load) begin
      // Restart from any state; a pending rk_req is dropped
      store[0] <= key_in;
      prev_key <= key_in;
      cnt      <= 4'd1;
      ptr      <= 4'd0;
      rk_out   <= '0;
      state    <= ST_EXPAND;
    end else begin
      case (state)
        ST_EXPAND: begin
          store[cnt] <= next_key;
          prev_key   <= next_key;
          if (cnt == LAST_IDX) begin
            // Last key is presented straight from the step output
            state  <= ST_READY;
            ptr    <= LAST_IDX;
            rk_out <= next_key;
            cnt    <= 4'd0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_READY: begin
          if (rk_req) begin
            if (ptr == 4'd0) begin
              ptr    <= LAST_IDX;
              rk_out <= store[NR];
            end else begin
              ptr    <= ptr - 4'd1;
              rk_out <= store[ptr - 4'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_decr_key_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_decr_key_sched
// Brief  : Directed self-checking bench for aes_decr_key_sched using FIPS-197
//          key-expansion vectors. Define AES_KS_ZEROIZE_EN to also exercise
//          key_clear.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aes_decr_key_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, key_ready, rk_valid, rk_last;
  logic         rk_req = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
`ifdef AES_KS_ZEROIZE_EN
  logic         key_clear = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // FIPS-197 A.1 expansion of 2b7e1516...
  logic [127:0] fips_rk [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_decr_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .busy      (busy),
    .key_ready (key_ready),
    .rk_valid  (rk_valid),
    .rk_req    (rk_req),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last)
`ifdef AES_KS_ZEROIZE_EN
    ,
    .key_clear (key_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse key_load for one edge, then let expansion run to READY
  task automatic load_and_wait(input logic [127:0] k);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if ({busy, key_ready, rk_valid, rk_last} !== 4'b0000 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL reset: flags=%b idx=%0d out=%h required all zero",
               {busy, key_ready, rk_valid, rk_last}, rk_idx, rk_out);
    end
  endtask

  task automatic test_expand_latency();
    key_in   = KEY_A;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      checks++;
      if (busy !== 1'b1 || key_ready !== 1'b0 || rk_valid !== 1'b0) begin
        failures++;
        $display("FAIL expand_edge%0d: busy=%b ready=%b valid=%b required 1/0/0",
                 e, busy, key_ready, rk_valid);
      end
      if (e < 10) tick();
    end
    tick();
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b1 || rk_valid !== 1'b1 || rk_idx !== 4'd10
        || rk_out !== fips_rk[10] || rk_last !== 1'b0) begin
      failures++;
      $display("FAIL expand_ready: busy=%b ready=%b valid=%b idx=%0d out=%h required 0/1/1 idx 10 out %h",
               busy, key_ready, rk_valid, rk_idx, rk_out, fips_rk[10]);
    end
  endtask

  task automatic test_serve_order();
    rk_req = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      checks++;
      if (rk_idx !== 4'(i) || rk_out !== fips_rk[i] || rk_last !== (i == 0) || rk_valid !== 1'b1) begin
        failures++;
        $display("FAIL serve_idx%0d: idx=%0d out=%h last=%b valid=%b required out %h",
                 i, rk_idx, rk_out, rk_last, rk_valid, fips_rk[i]);
      end
      tick();
    end
    rk_req = 1'b0;
    checks++;
    if (rk_idx !== 4'd10 || rk_out !== fips_rk[10] || key_ready !== 1'b1 || rk_last !== 1'b0) begin
      failures++;
      $display("FAIL serve_wrap: idx=%0d out=%h ready=%b required idx 10 out %h ready 1",
               rk_idx, rk_out, key_ready, fips_rk[10]);
    end
    // No request: output must hold
    tick();
    checks++;
    if (rk_idx !== 4'd10 || rk_out !== fips_rk[10]) begin
      failures++;
      $display("FAIL serve_hold: idx=%0d out=%h required idx 10", rk_idx, rk_out);
    end
  endtask

  task automatic test_restart_mid_expand();
    key_in   = KEY_A;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (3) tick();
    // Second load sampled at edge 5; rk_req held to show it is ignored while not valid
    key_in   = KEY_B;
    key_load = 1'b1;
    rk_req   = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (9) tick();
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL restart_edge10: busy=%b ready=%b out=%h required busy 1 ready 0 out 0",
               busy, key_ready, rk_out);
    end
    tick();
    rk_req = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || rk_idx !== 4'd10 || rk_out !== B_RK10) begin
      failures++;
      $display("FAIL restart_rk10: ready=%b idx=%0d out=%h required ready 1 idx 10 out %h",
               key_ready, rk_idx, rk_out, B_RK10);
    end
    rk_req = 1'b1;
    repeat (10) tick();
    rk_req = 1'b0;
    checks++;
    if (rk_idx !== 4'd0 || rk_out !== KEY_B || rk_last !== 1'b1) begin
      failures++;
      $display("FAIL restart_rk0: idx=%0d out=%h last=%b required idx 0 out %h last 1",
               rk_idx, rk_out, rk_last, KEY_B);
    end
  endtask

  task automatic test_rst_priority();
    key_in   = KEY_A;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (4) tick();
    rst      = 1'b1;
    key_load = 1'b1;
    tick();
    rst      = 1'b0;
    key_load = 1'b0;
    checks++;
    if ({busy, key_ready, rk_valid, rk_last} !== 4'b0000 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_expand: flags=%b idx=%0d out=%h required all zero",
               {busy, key_ready, rk_valid, rk_last}, rk_idx, rk_out);
    end
    load_and_wait(KEY_A);
    rk_req = 1'b1;
    repeat (6) tick();
    rk_req = 1'b0;
    checks++;
    if (rk_idx !== 4'd4 || rk_out !== fips_rk[4]) begin
      failures++;
      $display("FAIL ready_idx4: idx=%0d out=%h required idx 4 out %h", rk_idx, rk_out, fips_rk[4]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, key_ready, rk_valid, rk_last} !== 4'b0000 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL rst_ready: flags=%b idx=%0d out=%h required all zero",
               {busy, key_ready, rk_valid, rk_last}, rk_idx, rk_out);
    end
    rk_req = 1'b1;
    repeat (2) tick();
    rk_req = 1'b0;
    checks++;
    if ({busy, key_ready, rk_valid, rk_last} !== 4'b0000 || rk_idx !== 4'd0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL req_in_idle: flags=%b idx=%0d out=%h required all zero",
               {busy, key_ready, rk_valid, rk_last}, rk_idx, rk_out);
    end
  endtask

  task automatic test_load_and_req();
    load_and_wait(KEY_A);
    rk_req = 1'b1;
    tick();
    // now idx 9; load wins over a simultaneous request
    key_in   = KEY_B;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    rk_req   = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0 || rk_valid !== 1'b0 || rk_out !== 128'h0) begin
      failures++;
      $display("FAIL load_req_same: busy=%b ready=%b valid=%b out=%h required 1/0/0 out 0",
               busy, key_ready, rk_valid, rk_out);
    end
    repeat (10) tick();
    checks++;
    if (key_ready !== 1'b1 || rk_idx !== 4'd10 || rk_out !== B_RK10) begin
      failures++;
      $display("FAIL load_req_result: ready=%b idx=%0d out=%h required idx 10 out %h",
               key_ready, rk_idx, rk_out, B_RK10);
    end
  endtask

`ifdef AES_KS_ZEROIZE_EN
  task automatic test_zeroize();
    load_and_wait(KEY_A);
    key_clear = 1'b1;
    key_load  = 1'b1;
    tick();
    key_clear = 1'b0;
    key_load  = 1'b0;
    checks++;
    if ({busy, key_ready, rk_valid, rk_last} !== 4'b0000 || rk_out !== 128'h0 || rk_idx !== 4'd0) begin
      failures++;
      $display("FAIL zeroize: flags=%b idx=%0d out=%h required all zero",
               {busy, key_ready, rk_valid, rk_last}, rk_idx, rk_out);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_expand_latency();
    test_serve_order();
    test_restart_mid_expand();
    test_rst_priority();
    test_load_and_req();
`ifdef AES_KS_ZEROIZE_EN
    test_zeroize();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
